pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC value loaded on reset.
REQ-002 Parameter MAX_WAIT, default 16, SHALL be the number of cycles FETCH waits for ImemAck before timeout.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset_L  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 ImemReq  output  1  SHALL be the instruction-fetch request; 1 only in FETCH.
REQ-006 ImemAddr  output  64  SHALL carry the current PC.
REQ-007 ImemAck  input  1  SHALL be the memory response strobe; it is valid with ImemData.
REQ-008 ImemData  input  32  SHALL be the fetched instruction word.
REQ-009 Instr  output  32  SHALL be the latched instruction; InstrValid output 1 SHALL be high in EXEC.
REQ-010 ExecDone  input  1  SHALL mark the datapath cycle in which Branch, Uncondbranch, ALUZero, SignExtImm64 (64) and Halt are valid.
REQ-011 CurrentPC  output  64  SHALL expose the PC register; State output 2 SHALL expose the FSM encoding.
REQ-012 Fault  output  1  SHALL flag a fetch timeout; it is sticky until reset.

Function
REQ-013 The FSM SHALL have the states IDLE=0, FETCH=1, EXEC=2 and HALT=3.
REQ-014 IDLE SHALL last exactly one cycle after reset deassertion and then go to FETCH.
REQ-015 FETCH SHALL hold ImemReq=1 and ImemAddr=PC stable; on ImemAck it SHALL latch ImemData into Instr and go to EXEC next cycle.
REQ-016 FETCH SHALL count wait cycles; reaching MAX_WAIT without ImemAck SHALL set Fault and go to HALT.
REQ-017 ImemAck outside FETCH SHALL be ignored.
REQ-018 EXEC SHALL hold Instr stable and InstrValid=1 until ExecDone.
REQ-019 On ExecDone, Uncondbranch=1 SHALL load PC+(SignExtImm64<<2), taking priority over the conditional branch.
REQ-020 Otherwise, on ExecDone, Branch=1 with ALUZero=1 SHALL load PC+(SignExtImm64<<2).
REQ-021 Otherwise, on ExecDone, the sequencer SHALL load PC+4.
REQ-022 All PC arithmetic SHALL be modulo 2^64: bits shifted out of the immediate are lost and the sum wraps silently.
REQ-023 On ExecDone with Halt=0, the next state SHALL be FETCH, giving a 1-cycle EXEC->FETCH turnaround.
REQ-024 On ExecDone with Halt=1, the PC SHALL still update per REQ-019..021 and the next state SHALL be HALT.
REQ-025 HALT SHALL be absorbing: ImemReq=0, InstrValid=0 and PC frozen until reset.
REQ-026 The PC SHALL change only on an ExecDone cycle.

Reset
REQ-027 Assertion of Reset_L SHALL immediately set State=IDLE, PC=RESET_PC, Instr=0, InstrValid=0, ImemReq=0, Fault=0, the wait counter=0 and any enabled counters=0, without waiting for a clock edge.
REQ-028 Reset asserted mid-handshake SHALL drop ImemReq in the same cycle and discard any pending ImemAck.

Configuration
REQ-029 With PC_SEQ_PERFCNT_EN defined, the block SHALL add the 32-bit outputs RetireCnt and TakenCnt.
REQ-030 RetireCnt SHALL increment on each ExecDone and TakenCnt on each ExecDone that takes a branch (REQ-019/020); both wrap at 2^32.
REQ-031 Without PC_SEQ_PERFCNT_EN, neither port nor the counters SHALL exist, and behaviour SHALL otherwise be identical.

Verification
REQ-032 Reset with RESET_PC=0x1000, ImemAck after 2 cycles, ExecDone with no branch -> ImemAddr 0x1000 and then 0x1004; State follows 0,1,1,1,2,1.
REQ-033 PC=0x2000, Uncondbranch=1 and Branch=1 with ALUZero=0, SignExtImm64=-4 -> next PC=0x1FF0.
REQ-034 PC=0x2000, Branch=1: with ALUZero=1 and imm=3, next PC=0x200C; with ALUZero=0, next PC=0x2004.
REQ-035 No ImemAck for MAX_WAIT=16 cycles -> Fault=1, State=3 and ImemReq=0; later ImemAck pulses change nothing.
REQ-036 ExecDone with Halt=1 and a taken branch to 0x3000 -> CurrentPC=0x3000 and State=3; Reset_L pulsed low mid-FETCH -> ImemReq=0 asynchronously and PC=RESET_PC.
REQ-037 With PC_SEQ_PERFCNT_EN, 5 instructions of which 2 take a branch -> RetireCnt=5 and TakenCnt=2.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch channel between the PC sequencer (master) and the
// instruction memory (slave).
interface pc_sequencer_if;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemData;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemAck,
        input  ImemData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemAck,
        output ImemData
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH -> EXEC loop with fetch timeout and HALT.
// Optional retire/taken-branch counters are enabled with `define PC_SEQ_PERFCNT_EN.
module pc_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        CLK,
    input  logic        Reset_L,
    pc_sequencer_if.master imem,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        ExecDone,
    input  logic        Branch,
    input  logic        Uncondbranch,
    input  logic        ALUZero,
    input  logic [63:0] SignExtImm64,
    input  logic        Halt,
    output logic [63:0] CurrentPC,
    output logic [1:0]  State,
    output logic        Fault
`ifdef PC_SEQ_PERFCNT_EN
    ,
    output logic [31:0] RetireCnt,
    output logic [31:0] TakenCnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    state_t          state_r;
    state_t          state_next_s;
    logic [63:0]     pc_r;
    logic [63:0]     pc_next_s;
    logic [31:0]     instr_r;
    logic            req_r;
    logic            valid_r;
    logic            fault_r;
    logic [WCW-1:0]  wait_cnt_r;
    logic [WCW-1:0]  wait_next_s;
    logic            fault_set_s;
    logic            instr_load_s;
    logic            pc_load_s;
    logic            taken_s;

    // Next-state, fetch-timeout and PC-update decisions.
    always_comb begin
        state_next_s = state_r;
        wait_next_s  = wait_cnt_r;
        fault_set_s  = 1'b0;
        instr_load_s = 1'b0;
        pc_load_s    = 1'b0;
        taken_s      = Uncondbranch | (Branch & ALUZero);
        // Shift and add are both truncated to 64 bits, so wrap is silent.
        if (taken_s) begin
            pc_next_s = pc_r + (SignExtImm64 << 2);
        end else begin
            pc_next_s = pc_r + 64'd4;
        end
        case (state_r)
            IDLE: begin
                state_next_s = FETCH;
                wait_next_s  = '0;
            end
            FETCH: begin
                if (imem.ImemAck) begin
                    state_next_s = EXEC;
                    instr_load_s = 1'b1;
                    wait_next_s  = '0;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = HALT;
                    fault_set_s  = 1'b1;
                    wait_next_s  = '0;
                end else begin
                    wait_next_s  = wait_cnt_r + WCW'(1);
                end
            end
            EXEC: begin
                if (ExecDone) begin
                    pc_load_s    = 1'b1;
                    state_next_s = Halt ? HALT : FETCH;
                end else begin
                    state_next_s = EXEC;
                end
            end
            HALT: begin
                state_next_s = HALT;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, PC, instruction latch and registered handshake outputs.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_r    <= IDLE;
            pc_r       <= RESET_PC;
            instr_r    <= 32'h0;
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
            fault_r    <= 1'b0;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_next_s;
            req_r      <= (state_next_s == FETCH);
            valid_r    <= (state_next_s == EXEC);
            fault_r    <= fault_r | fault_set_s;
            if (instr_load_s) begin
                instr_r <= imem.ImemData;
            end
            if (pc_load_s) begin
                pc_r <= pc_next_s;
            end
        end
    end

`ifdef PC_SEQ_PERFCNT_EN
    logic [31:0] retire_cnt_r;
    logic [31:0] taken_cnt_r;

    // Retired-instruction and taken-branch counters, wrapping at 2^32.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            retire_cnt_r <= 32'd0;
            taken_cnt_r  <= 32'd0;
        end else if (pc_load_s) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
            if (taken_s) begin
                taken_cnt_r <= taken_cnt_r + 32'd1;
            end
        end
    end

    assign RetireCnt = retire_cnt_r;
    assign TakenCnt  = taken_cnt_r;
`endif

    assign imem.ImemReq  = req_r;
    assign imem.ImemAddr = pc_r;
    assign Instr         = instr_r;
    assign InstrValid    = valid_r;
    assign CurrentPC     = pc_r;
    assign State         = state_r;
    assign Fault         = fault_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (RESET_PC=0x1000, MAX_WAIT=16).
module tb_pc_sequencer;

    localparam logic [63:0] RPC = 64'h1000;

    logic        CLK;
    logic        Reset_L;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        ExecDone;
    logic        Branch;
    logic        Uncondbranch;
    logic        ALUZero;
    logic [63:0] SignExtImm64;
    logic        Halt;
    logic [63:0] CurrentPC;
    logic [1:0]  State;
    logic        Fault;
`ifdef PC_SEQ_PERFCNT_EN
    logic [31:0] RetireCnt;
    logic [31:0] TakenCnt;
`endif

    pc_sequencer_if imem_bus ();

    pc_sequencer #(
        .RESET_PC (RPC),
        .MAX_WAIT (16)
    ) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .imem         (imem_bus),
        .Instr        (Instr),
        .InstrValid   (InstrValid),
        .ExecDone     (ExecDone),
        .Branch       (Branch),
        .Uncondbranch (Uncondbranch),
        .ALUZero      (ALUZero),
        .SignExtImm64 (SignExtImm64),
        .Halt         (Halt),
        .CurrentPC    (CurrentPC),
        .State        (State),
        .Fault        (Fault)
`ifdef PC_SEQ_PERFCNT_EN
        ,
        .RetireCnt    (RetireCnt),
        .TakenCnt     (TakenCnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        br;
        logic        ub;
        logic        az;
        logic [63:0] imm;
        logic        hl;
        logic [63:0] exp_pc;
        int unsigned ack_wait;
        int unsigned exec_wait;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;
    logic [63:0] pc_model;
    int unsigned retire_model = 0;
    int unsigned taken_model = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_exec();
        ExecDone = 1'b0; Branch = 1'b0; Uncondbranch = 1'b0;
        ALUZero = 1'b0; SignExtImm64 = 64'h0; Halt = 1'b0;
    endtask

    task automatic run_vec(input int i);
        logic [31:0] word;
        word = 32'hA500_0000 + 32'(i);
        check("fetch_state", {62'h0, State}, 64'd1);
        check("fetch_req", {63'h0, imem_bus.ImemReq}, 64'd1);
        check("fetch_addr", imem_bus.ImemAddr, pc_model);
        for (int k = 0; k < int'(vecs[i].ack_wait); k++) begin
            step();
            check("fetch_hold_state", {62'h0, State}, 64'd1);
            check("fetch_hold_addr", imem_bus.ImemAddr, pc_model);
        end
        imem_bus.ImemAck = 1'b1;
        imem_bus.ImemData = word;
        step();
        imem_bus.ImemAck = 1'b0;
        check("exec_state", {62'h0, State}, 64'd2);
        check("exec_valid", {63'h0, InstrValid}, 64'd1);
        check("exec_req_low", {63'h0, imem_bus.ImemReq}, 64'd0);
        check("exec_instr", {32'h0, Instr}, {32'h0, word});
        for (int k = 0; k < int'(vecs[i].exec_wait); k++) begin
            imem_bus.ImemAck = 1'b1;
            imem_bus.ImemData = 32'hDEAD_BEEF;
            step();
            imem_bus.ImemAck = 1'b0;
            check("exec_hold_instr", {32'h0, Instr}, {32'h0, word});
            check("exec_hold_pc", CurrentPC, pc_model);
            check("exec_hold_state", {62'h0, State}, 64'd2);
        end
        ExecDone = 1'b1;
        Branch = vecs[i].br;
        Uncondbranch = vecs[i].ub;
        ALUZero = vecs[i].az;
        SignExtImm64 = vecs[i].imm;
        Halt = vecs[i].hl;
        step();
        clear_exec();
        check($sformatf("next_pc_v%0d", i), CurrentPC, vecs[i].exp_pc);
        check($sformatf("next_state_v%0d", i), {62'h0, State}, vecs[i].hl ? 64'd3 : 64'd1);
        retire_model++;
        if (vecs[i].ub || (vecs[i].br && vecs[i].az)) taken_model++;
        pc_model = vecs[i].exp_pc;
    endtask

    initial begin
        //           br    ub    az    imm                     hl    exp_pc   ack exec
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 64'h0,                  1'b0, 64'h1004, 2, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 64'h3FF,                1'b0, 64'h2000, 0, 1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h1FF0, 1, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 64'h4,                  1'b0, 64'h2000, 0, 2};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 64'h3,                  1'b0, 64'h200C, 3, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'h2000, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 64'h3,                  1'b0, 64'h2004, 1, 1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 64'h64,                 1'b0, 64'h2008, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 1'b0, 64'h2008, 0, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 64'h3FFF_FFFF_FFFF_F7FE, 1'b0, 64'h0,    2, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 64'h0,                  1'b0, 64'h4,    0, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 64'hBFF,                1'b1, 64'h3000, 1, 1};

        Reset_L = 1'b0;
        imem_bus.ImemAck = 1'b0;
        imem_bus.ImemData = 32'h0;
        clear_exec();
        pc_model = RPC;
        step();
        step();
        check("rst_state", {62'h0, State}, 64'd0);
        check("rst_pc", CurrentPC, RPC);
        check("rst_instr", {32'h0, Instr}, 64'd0);
        check("rst_valid", {63'h0, InstrValid}, 64'd0);
        check("rst_req", {63'h0, imem_bus.ImemReq}, 64'd0);
        check("rst_fault", {63'h0, Fault}, 64'd0);
`ifdef PC_SEQ_PERFCNT_EN
        check("rst_retire", {32'h0, RetireCnt}, 64'd0);
        check("rst_taken", {32'h0, TakenCnt}, 64'd0);
`endif
        Reset_L = 1'b1;
        check("idle_after_rst", {62'h0, State}, 64'd0);
        step();

        for (int i = 0; i < NV; i++) begin
            run_vec(i);
        end
`ifdef PC_SEQ_PERFCNT_EN
        check("retire_cnt", {32'h0, RetireCnt}, 64'(retire_model));
        check("taken_cnt", {32'h0, TakenCnt}, 64'(taken_model));
`endif

        // HALT must absorb acks and exec strobes.
        for (int k = 0; k < 3; k++) begin
            imem_bus.ImemAck = 1'b1;
            ExecDone = 1'b1;
            Uncondbranch = 1'b1;
            SignExtImm64 = 64'h10;
            step();
            check("halt_state", {62'h0, State}, 64'd3);
            check("halt_pc", CurrentPC, 64'h3000);
            check("halt_req", {63'h0, imem_bus.ImemReq}, 64'd0);
            check("halt_valid", {63'h0, InstrValid}, 64'd0);
        end
        imem_bus.ImemAck = 1'b0;
        clear_exec();

        // Asynchronous reset from HALT, then again in the middle of a FETCH cycle.
        #2;
        Reset_L = 1'b0;
        #1;
        check("async_rst_pc", CurrentPC, RPC);
        check("async_rst_state", {62'h0, State}, 64'd0);
        step();
        Reset_L = 1'b1;
        step();
        step();
        check("pre_rst_req", {63'h0, imem_bus.ImemReq}, 64'd1);
        imem_bus.ImemAck = 1'b1;
        imem_bus.ImemData = 32'h1234_5678;
        #2;
        Reset_L = 1'b0;
        #1;
        check("midfetch_req_drop", {63'h0, imem_bus.ImemReq}, 64'd0);
        check("midfetch_pc", CurrentPC, RPC);
        step();
        check("midfetch_instr", {32'h0, Instr}, 64'd0);
        imem_bus.ImemAck = 1'b0;
        Reset_L = 1'b1;

        // Fetch timeout: 16 FETCH cycles without ack.
        step();
        check("to_fetch", {62'h0, State}, 64'd1);
        for (int k = 0; k < 15; k++) begin
            step();
            check("to_wait_state", {62'h0, State}, 64'd1);
            check("to_wait_fault", {63'h0, Fault}, 64'd0);
        end
        step();
        check("to_state", {62'h0, State}, 64'd3);
        check("to_fault", {63'h0, Fault}, 64'd1);
        check("to_req", {63'h0, imem_bus.ImemReq}, 64'd0);
        for (int k = 0; k < 2; k++) begin
            imem_bus.ImemAck = 1'b1;
            imem_bus.ImemData = 32'hFFFF_0000;
            step();
            imem_bus.ImemAck = 1'b0;
            check("to_late_ack_state", {62'h0, State}, 64'd3);
            check("to_late_ack_fault", {63'h0, Fault}, 64'd1);
            check("to_late_ack_instr", {32'h0, Instr}, 64'd0);
            check("to_late_ack_pc", CurrentPC, RPC);
        end
        Reset_L = 1'b0;
        #1;
        check("fault_clear", {63'h0, Fault}, 64'd0);
        Reset_L = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
